// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: default field widths, index-width helper
// and the entry record seen by the issue and execute blocks.
package rob_pkg;

  localparam int ROB_DATA_W = 16;
  localparam int ROB_REG_W  = 3;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic                  alloc;
    logic                  done;
    logic                  reg_write;
    logic [ROB_REG_W-1:0]  addr;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire selector: the contiguous run of completed entries starting at head,
// as per-slot strobes plus the number of entries retiring.
module rob_retire_sel #(
  parameter int RET_W = 2,
  parameter int CNT_W = 2
) (
  input  logic [RET_W-1:0] done_win,
  output logic [RET_W-1:0] ret_vld,
  output logic [CNT_W-1:0] ret_cnt
);

  // Prefix-AND of the done window, counted as it goes
  always_comb begin
    logic run_s;
    run_s   = 1'b1;
    ret_vld = '0;
    ret_cnt = '0;
    for (int j = 0; j < RET_W; j++) begin
      run_s      = run_s & done_win[j];
      ret_vld[j] = run_s;
      if (run_s) begin
        ret_cnt = ret_cnt + CNT_W'(1);
      end else begin
        ret_cnt = ret_cnt;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_n.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire,
// with tail-truncating flush. Pointers carry a wrap bit above the index.
module reorder_buffer_n
  import rob_pkg::*;
#(
  parameter int  DEPTH      = 16,
  parameter int  DATA_WIDTH = ROB_DATA_W,
  parameter int  REG_W      = ROB_REG_W,
  parameter int  ALLOC_W    = 2,
  parameter int  WB_PORTS   = 2,
  parameter int  RET_W      = 2,
  parameter int  RD_PORTS   = 4,
  localparam int IDX_W      = idx_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ALLOC_W-1:0]             alloc_vld,
  output logic                           alloc_ready,
  output logic [ALLOC_W*IDX_W-1:0]       alloc_idx,
  input  logic [WB_PORTS-1:0]            wb_vld,
  input  logic [WB_PORTS*IDX_W-1:0]      wb_idx,
  input  logic [WB_PORTS*DATA_WIDTH-1:0] wb_data,
  input  logic [WB_PORTS-1:0]            wb_reg_write,
  input  logic [WB_PORTS*REG_W-1:0]      wb_addr,
  output logic [RET_W-1:0]               ret_vld,
  output logic [RET_W*DATA_WIDTH-1:0]    ret_data,
  output logic [RET_W-1:0]               ret_reg_write,
  output logic [RET_W*REG_W-1:0]         ret_addr,
  input  logic                           flush,
  input  logic [IDX_W-1:0]               flush_idx,
  input  logic [RD_PORTS*IDX_W-1:0]      rd_idx,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_done,
  output logic [IDX_W:0]                 count,
  output logic                           empty,
  output logic                           full
);

  localparam int PTR_W  = IDX_W + 1;
  localparam int ACNT_W = $clog2(ALLOC_W + 1);
  localparam int RCNT_W = $clog2(RET_W + 1);

  typedef struct packed {
    logic                  alloc;
    logic                  done;
    logic                  reg_write;
    logic [REG_W-1:0]      addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t             ent_r [DEPTH];
  logic [PTR_W-1:0]   head_r, tail_r;
  logic [PTR_W-1:0]   count_s;
  logic [ACNT_W-1:0]  n_alloc_s;
  logic [IDX_W-1:0]   ret_slot_s [RET_W];
  logic [RET_W-1:0]   done_win_s, ret_vld_s;
  logic [RCNT_W-1:0]  ret_cnt_s;
  logic [IDX_W-1:0]   flush_off_s;
  logic [DEPTH-1:0]   discard_s;
  logic [WB_PORTS-1:0] wb_ok_s;

  // Occupancy, allocation grant and the indices offered to the issue slots
  always_comb begin
    count_s     = tail_r - head_r;
    alloc_ready = ((PTR_W'(DEPTH) - count_s) >= PTR_W'(ALLOC_W)) && !flush;
    n_alloc_s   = '0;
    alloc_idx   = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_idx[k*IDX_W +: IDX_W] = tail_r[IDX_W-1:0] + IDX_W'(k);
      if (alloc_vld[k]) begin
        n_alloc_s = n_alloc_s + ACNT_W'(1);
      end else begin
        n_alloc_s = n_alloc_s;
      end
    end
  end

  assign count = count_s;
  assign empty = (count_s == '0);
  assign full  = (count_s == PTR_W'(DEPTH));

  // Entries younger than flush_idx (by age from head) are discarded; writebacks must land on live, kept entries
  always_comb begin
    logic [IDX_W-1:0] off_s;
    logic [IDX_W-1:0] wi_s;
    off_s       = '0;
    wi_s        = '0;
    flush_off_s = flush_idx - head_r[IDX_W-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      off_s        = IDX_W'(i) - head_r[IDX_W-1:0];
      discard_s[i] = flush && (off_s > flush_off_s);
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      wi_s       = wb_idx[p*IDX_W +: IDX_W];
      wb_ok_s[p] = wb_vld[p] && ent_r[wi_s].alloc && !discard_s[wi_s];
    end
  end

  // Done window from head, never reaching past the occupied entries
  always_comb begin
    for (int j = 0; j < RET_W; j++) begin
      ret_slot_s[j] = head_r[IDX_W-1:0] + IDX_W'(j);
      done_win_s[j] = ent_r[ret_slot_s[j]].done && (PTR_W'(j) < count_s);
    end
  end

  rob_retire_sel #(
    .RET_W (RET_W),
    .CNT_W (RCNT_W)
  ) u_retire_sel (
    .done_win (done_win_s),
    .ret_vld  (ret_vld_s),
    .ret_cnt  (ret_cnt_s)
  );

  // Retiring entry fields and operand read ports
  always_comb begin
    ret_data      = '0;
    ret_addr      = '0;
    ret_reg_write = '0;
    rd_data       = '0;
    rd_done       = '0;
    for (int j = 0; j < RET_W; j++) begin
      ret_data[j*DATA_WIDTH +: DATA_WIDTH] = ent_r[ret_slot_s[j]].data;
      ret_addr[j*REG_W +: REG_W]           = ent_r[ret_slot_s[j]].addr;
      ret_reg_write[j]                     = ent_r[ret_slot_s[j]].reg_write & ret_vld_s[j];
    end
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_data[r*DATA_WIDTH +: DATA_WIDTH] = ent_r[rd_idx[r*IDX_W +: IDX_W]].data;
      rd_done[r] = ent_r[rd_idx[r*IDX_W +: IDX_W]].alloc & ent_r[rd_idx[r*IDX_W +: IDX_W]].done;
    end
  end

  assign ret_vld = ret_vld_s;

  // Entry state and pointers; later loops win, so higher writeback ports override lower ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r <= '0;
      tail_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_ok_s[p]) begin
          ent_r[wb_idx[p*IDX_W +: IDX_W]].done      <= 1'b1;
          ent_r[wb_idx[p*IDX_W +: IDX_W]].data      <= wb_data[p*DATA_WIDTH +: DATA_WIDTH];
          ent_r[wb_idx[p*IDX_W +: IDX_W]].reg_write <= wb_reg_write[p];
          ent_r[wb_idx[p*IDX_W +: IDX_W]].addr      <= wb_addr[p*REG_W +: REG_W];
        end
      end
      for (int k = 0; k < ALLOC_W; k++) begin
        if (alloc_ready && alloc_vld[k]) begin
          ent_r[alloc_idx[k*IDX_W +: IDX_W]].alloc <= 1'b1;
          ent_r[alloc_idx[k*IDX_W +: IDX_W]].done  <= 1'b0;
        end
      end
      for (int j = 0; j < RET_W; j++) begin
        if (ret_vld_s[j]) begin
          ent_r[ret_slot_s[j]].alloc <= 1'b0;
          ent_r[ret_slot_s[j]].done  <= 1'b0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (discard_s[i]) begin
          ent_r[i].alloc <= 1'b0;
          ent_r[i].done  <= 1'b0;
        end
      end
      head_r <= head_r + PTR_W'(ret_cnt_s);
      if (flush) begin
        tail_r <= head_r + PTR_W'(flush_off_s) + PTR_W'(1);
      end else if (alloc_ready) begin
        tail_r <= tail_r + PTR_W'(n_alloc_s);
      end else begin
        tail_r <= tail_r;
      end
    end
  end

endmodule
